// File: rtl/cache_memory_responder_if.sv
// rtl/cache_memory_responder_if.sv - request/response bus between cache controller and memory responder
interface cache_memory_responder_if #(
  parameter int BLK_ADDR_W = 13,
  parameter int OFFSET_W   = 4,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [BLK_ADDR_W-1:0] req_block_addr;
  logic [OFFSET_W-1:0]   req_offset;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;
  logic [OFFSET_W-1:0]   rsp_word_idx;
  logic                  rsp_last;
  logic                  wr_done;
  logic                  busy;

  // Cache controller side: issues requests, accepts burst words.
  modport master (
    output req_valid, req_write, req_block_addr, req_offset, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_word_idx, rsp_last, wr_done, busy
  );

  // Memory side: accepts requests, produces burst words and write acks.
  modport slave (
    input  req_valid, req_write, req_block_addr, req_offset, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_word_idx, rsp_last, wr_done, busy
  );
endinterface

// File: rtl/cache_memory_responder.sv
// rtl/cache_memory_responder.sv - main-memory responder serving block refill bursts and single-word writes
module cache_memory_responder #(
  parameter int BLK_ADDR_W   = 13,
  parameter int OFFSET_W     = 4,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  cache_memory_responder_if.slave bus
);

  localparam int ADDR_W = BLK_ADDR_W + OFFSET_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [OFFSET_W-1:0] LAST_IDX = {OFFSET_W{1'b1}};
  localparam logic [3:0]          LAT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_WRITE
  } state_t;

  // Default content of a word is its block address plus its word index.
  function automatic logic [DATA_W-1:0] init_word(
    input logic [BLK_ADDR_W-1:0] b,
    input logic [OFFSET_W-1:0]   w
  );
    return DATA_W'(b) + DATA_W'(w);
  endfunction

  // The array holds each word XOR its default content. A zero power-up
  // array therefore reads back as block+word without any load sequence,
  // and a written word reads back exactly as written.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            lat_cnt;
  logic [BLK_ADDR_W-1:0] blk_q;
  logic [OFFSET_W-1:0]   idx_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  rsp_last_q;
  logic                  wr_done_q;
  logic                  busy_q;

  logic                  accept;
  logic [OFFSET_W-1:0]   next_idx;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_word;

  assign accept = bus.req_valid && req_ready_q;

  // Word to present next: word 0 when leaving WAIT, otherwise the successor.
  assign next_idx = (state == S_WAIT) ? '0 : idx_q + OFFSET_W'(1);
  assign rd_addr  = {blk_q, next_idx};
  assign rd_word  = mem[rd_addr] ^ init_word(blk_q, next_idx);

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_word_idx = idx_q;
  assign bus.rsp_last     = rsp_last_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.busy         = busy_q;

  // Write-through commits on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write) begin
      mem[{bus.req_block_addr, bus.req_offset}] <=
        bus.req_wdata ^ init_word(bus.req_block_addr, bus.req_offset);
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      blk_q       <= '0;
      idx_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            blk_q       <= bus.req_block_addr;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.req_write) begin
              state     <= S_WRITE;
              wr_done_q <= 1'b1;
            end else begin
              state   <= S_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end

        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state       <= S_BURST;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_word;
            idx_q       <= '0;
            rsp_last_q  <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        S_BURST: begin
          if (bus.rsp_ready) begin
            if (idx_q == LAST_IDX) begin
              state       <= S_IDLE;
              rsp_valid_q <= 1'b0;
              rsp_last_q  <= 1'b0;
              rsp_data_q  <= '0;
              idx_q       <= '0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              idx_q      <= next_idx;
              rsp_data_q <= rd_word;
              rsp_last_q <= (next_idx == LAST_IDX);
            end
          end
        end

        S_WRITE: begin
          state       <= S_IDLE;
          wr_done_q   <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_memory_responder.sv
// tb/tb_cache_memory_responder.sv - directed self-checking bench for cache_memory_responder
module tb_cache_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [12:0] req_blk;
  logic [3:0]  req_off;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_w [16];

  cache_memory_responder_if #(.BLK_ADDR_W(13), .OFFSET_W(4), .DATA_W(32)) if0 ();
  cache_memory_responder_if #(.BLK_ADDR_W(13), .OFFSET_W(4), .DATA_W(32)) if1 ();

  assign if0.req_valid      = req_valid & ~sel;
  assign if0.req_write      = req_write;
  assign if0.req_block_addr = req_blk;
  assign if0.req_offset     = req_off;
  assign if0.req_wdata      = req_wdata;
  assign if0.rsp_ready      = rsp_ready;

  assign if1.req_valid      = req_valid & sel;
  assign if1.req_write      = req_write;
  assign if1.req_block_addr = req_blk;
  assign if1.req_offset     = req_off;
  assign if1.req_wdata      = req_wdata;
  assign if1.rsp_ready      = rsp_ready;

  cache_memory_responder #(.READ_LATENCY(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  cache_memory_responder #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic        o_req_ready, o_rsp_valid, o_rsp_last, o_wr_done, o_busy;
  logic [31:0] o_rsp_data;
  logic [3:0]  o_idx;

  assign o_req_ready = sel ? if1.req_ready    : if0.req_ready;
  assign o_rsp_valid = sel ? if1.rsp_valid    : if0.rsp_valid;
  assign o_rsp_last  = sel ? if1.rsp_last     : if0.rsp_last;
  assign o_wr_done   = sel ? if1.wr_done      : if0.wr_done;
  assign o_busy      = sel ? if1.busy         : if0.busy;
  assign o_rsp_data  = sel ? if1.rsp_data     : if0.rsp_data;
  assign o_idx       = sel ? if1.rsp_word_idx : if0.rsp_word_idx;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [12:0] b, input logic [3:0] o, input logic [31:0] d);
    chk("req_ready_before_accept", 32'(o_req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_blk   = b;
    req_off   = o;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  // Called right after a read accept edge; checks latency, then every word against exp_w.
  task automatic run_burst(input int lat, input bit stall);
    logic pat [4];
    logic rdy;
    int   got;
    int   c;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < lat; k++) begin
      chk("latency_valid_low", 32'(o_rsp_valid), 32'd0);
      chk("latency_ready_low", 32'(o_req_ready), 32'd0);
      step();
    end
    chk("first_valid", 32'(o_rsp_valid), 32'd1);
    got = 0;
    c   = 0;
    while (got < 16 && c < 200) begin
      chk("burst_valid", 32'(o_rsp_valid), 32'd1);
      chk("burst_idx", 32'(o_idx), 32'(got));
      chk("burst_data", o_rsp_data, exp_w[got]);
      chk("burst_last", 32'(o_rsp_last), (got == 15) ? 32'd1 : 32'd0);
      chk("burst_req_ready", 32'(o_req_ready), 32'd0);
      chk("burst_wr_done", 32'(o_wr_done), 32'd0);
      rdy = stall ? pat[c % 4] : 1'b1;
      rsp_ready = rdy;
      step();
      if (rdy) got++;
      c++;
    end
    rsp_ready = 1'b1;
    chk("burst_word_count", 32'(got), 32'd16);
    chk("end_valid_low", 32'(o_rsp_valid), 32'd0);
    chk("end_req_ready", 32'(o_req_ready), 32'd1);
    chk("end_busy_low", 32'(o_busy), 32'd0);
  endtask

  initial begin
    sel       = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_blk   = '0;
    req_off   = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_data", o_rsp_data, 32'd0);
    chk("rst_idx", 32'(o_idx), 32'd0);
    chk("rst_last", 32'(o_rsp_last), 32'd0);
    chk("rst_wr_done", 32'(o_wr_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", 32'(o_req_ready), 32'd1);

    // Plain read of block 0x005: words 5..20
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h5 + 32'(i);
    issue(1'b0, 13'h005, 4'd0, 32'd0);
    chk("read_busy", 32'(o_busy), 32'd1);
    run_burst(4, 1'b0);

    // Write 0x1A3/7, then read back
    issue(1'b1, 13'h1A3, 4'd7, 32'hDEADBEEF);
    chk("wr_done_pulse", 32'(o_wr_done), 32'd1);
    chk("wr_req_ready_low", 32'(o_req_ready), 32'd0);
    chk("wr_busy", 32'(o_busy), 32'd1);
    step();
    chk("wr_done_clear", 32'(o_wr_done), 32'd0);
    chk("wr_req_ready_back", 32'(o_req_ready), 32'd1);
    chk("wr_busy_clear", 32'(o_busy), 32'd0);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h1A3 + 32'(i);
    exp_w[7] = 32'hDEADBEEF;
    issue(1'b0, 13'h1A3, 4'd0, 32'd0);
    run_burst(4, 1'b0);

    // Top block with stalling consumer; last word 8206
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h1FFF + 32'(i);
    issue(1'b0, 13'h1FFF, 4'd0, 32'd0);
    run_burst(4, 1'b1);

    // Reset after six words of block 0x010
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h10 + 32'(i);
    issue(1'b0, 13'h010, 4'd0, 32'd0);
    repeat (4) step();
    for (int k = 0; k < 6; k++) begin
      chk("pre_rst_idx", 32'(o_idx), 32'(k));
      chk("pre_rst_data", o_rsp_data, exp_w[k]);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_rsp_valid), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_idx", 32'(o_idx), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_ready_back", 32'(o_req_ready), 32'd1);
    issue(1'b0, 13'h010, 4'd0, 32'd0);
    run_burst(4, 1'b0);

    // Write held pending during a burst of block 0x020
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h20 + 32'(i);
    issue(1'b0, 13'h020, 4'd0, 32'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_blk   = 13'h020;
    req_off   = 4'd3;
    req_wdata = 32'h12345678;
    run_burst(4, 1'b0);
    step();
    chk("pending_wr_done", 32'(o_wr_done), 32'd1);
    chk("pending_wr_ready_low", 32'(o_req_ready), 32'd0);
    req_valid = 1'b0;
    step();
    chk("pending_wr_done_clear", 32'(o_wr_done), 32'd0);
    exp_w[3] = 32'h12345678;
    issue(1'b0, 13'h020, 4'd0, 32'd0);
    run_burst(4, 1'b0);

    // Minimum latency instance, block 0
    sel = 1'b1;
    for (int i = 0; i < 16; i++) exp_w[i] = 32'(i);
    issue(1'b0, 13'h000, 4'd0, 32'd0);
    run_burst(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
